// File: rtl/qupls_reg_alias_table.sv
// Four-lane register alias table with intra-group bypass and map checkpoints.
// Renames sources/destinations one cycle after sampling; restore rewinds the map.
module qupls_reg_alias_table #(
  parameter int AREGS = 64,
  parameter int PREGS = 192,
  parameter int NCHK  = 4,
  localparam int AW = $clog2(AREGS),
  localparam int TW = $clog2(PREGS),
  localparam int CW = $clog2(NCHK)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic [3:0]    vld_i,
  input  logic [3:0]    wr_i,
  input  logic [AW-1:0] rs1_i [4],
  input  logic [AW-1:0] rs2_i [4],
  input  logic [AW-1:0] rd_i [4],
  input  logic [TW-1:0] wo_i [4],
  input  logic          chk_save,
  input  logic          chk_restore,
  input  logic [CW-1:0] chk_id,
  output logic [3:0]    vld_o,
  output logic [TW-1:0] prs1_o [4],
  output logic [TW-1:0] prs2_o [4],
  output logic [TW-1:0] prd_o [4],
  output logic [TW-1:0] prd_old_o [4]
);

  logic [TW-1:0] map_q [AREGS];
  logic [TW-1:0] map_nxt [AREGS];
  logic [TW-1:0] chk_q [NCHK][AREGS];

  logic [3:0]    wen;
  logic [TW-1:0] prs1_c [4];
  logic [TW-1:0] prs2_c [4];
  logic [TW-1:0] prd_c [4];
  logic [TW-1:0] prd_old_c [4];

  assign wen = vld_i & wr_i;

  // Later lanes overwrite earlier matches, so the highest earlier writer wins.
  always_comb begin
    map_nxt = map_q;
    for (int n = 0; n < 4; n++) begin
      prs1_c[n]    = map_q[rs1_i[n]];
      prs2_c[n]    = map_q[rs2_i[n]];
      prd_old_c[n] = map_q[rd_i[n]];
      prd_c[n]     = '0;
      for (int m = 0; m < n; m++) begin
        if (wen[m] && rd_i[m] == rs1_i[n]) prs1_c[n] = wo_i[m];
        if (wen[m] && rd_i[m] == rs2_i[n]) prs2_c[n] = wo_i[m];
        if (wen[m] && rd_i[m] == rd_i[n])  prd_old_c[n] = wo_i[m];
      end
      if (rs1_i[n] == '0) prs1_c[n] = '0;
      if (rs2_i[n] == '0) prs2_c[n] = '0;
      if (wen[n] && rd_i[n] != '0) begin
        prd_c[n] = wo_i[n];
        map_nxt[rd_i[n]] = wo_i[n];
      end else begin
        prd_old_c[n] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < AREGS; a++) begin
        map_q[a] <= TW'(a);
        for (int c = 0; c < NCHK; c++) chk_q[c][a] <= TW'(a);
      end
      vld_o <= '0;
      for (int n = 0; n < 4; n++) begin
        prs1_o[n]    <= '0;
        prs2_o[n]    <= '0;
        prd_o[n]     <= '0;
        prd_old_o[n] <= '0;
      end
    end else if (chk_restore) begin
      map_q <= chk_q[chk_id];
      vld_o <= '0;
    end else begin
      // A save during stall captures the held map, otherwise the post-group map.
      if (chk_save) chk_q[chk_id] <= stall ? map_q : map_nxt;
      if (!stall) begin
        map_q     <= map_nxt;
        vld_o     <= vld_i;
        prs1_o    <= prs1_c;
        prs2_o    <= prs2_c;
        prd_o     <= prd_c;
        prd_old_o <= prd_old_c;
      end
    end
  end

endmodule
